// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder cell fed LSB first, start/ready/done handshake
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             hs, hc, cs, cc;

   // full-adder cell built from two half adders and an OR
   always_comb begin
      hs = a_q[0] ^ b_q[0];
      hc = a_q[0] & b_q[0];
      cs = hs ^ carry_q;
      cc = hc | (carry_q & hs);
   end

   // sequencer next-state: accept in IDLE, one bit per edge in RUN, single DONE cycle
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      if (state_q == S_IDLE && start) begin
         a_d     = op_a;
         b_d     = op_b;
         carry_d = cin;
         cnt_d   = '0;
         sum_d   = '0;
         state_d = S_RUN;
      end else if (state_q == S_RUN) begin
         sum_d   = WIDTH'({cs, sum_q} >> 1);
         carry_d = cc;
         a_d     = a_q >> 1;
         b_d     = b_q >> 1;
         cnt_d   = cnt_q + 1'b1;
         cout_d  = (cnt_q == CW'(WIDTH - 1)) ? cc : cout_q;
         state_d = (cnt_q == CW'(WIDTH - 1)) ? S_DONE : S_RUN;
      end else if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end
   end

   // state registers; async reset drops any in-flight add
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: random and directed adds checked against a+b+cin arithmetic
module tb_serial_adder_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, cin = 1'b0;
   logic [7:0] op_a = '0, op_b = '0;
   logic       ready, busy, done, cout;
   logic [7:0] sum;
   logic       s1_start = 1'b0, s1_a = 1'b0, s1_b = 1'b0, s1_cin = 1'b0;
   logic       s1_ready, s1_busy, s1_done, s1_sum, s1_cout;
   int         total = 0, bad = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
      .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1_start), .op_a(s1_a), .op_b(s1_b), .cin(s1_cin),
      .ready(s1_ready), .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   // one complete add on the 8-bit unit; operands scrambled after acceptance
   task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c);
      int n;
      logic [8:0] e;
      e = {1'b0, a} + {1'b0, b} + {8'd0, c};
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_before", ready, 1);
      start = 1'b1; op_a = a; op_b = b; cin = c;
      @(negedge clk);
      start = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
      check("busy_run", busy, 1);
      wait_done(n);
      check("latency", n, 8);
      check("sum", sum, e[7:0]);
      check("cout", cout, e[8]);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("ready_after", ready, 1);
   endtask

   initial begin
      int n;
      logic [8:0] e;
      logic [1:0] e1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);

      run_add(8'h5A, 8'h33, 1'b0);
      run_add(8'hFF, 8'h01, 1'b0);
      run_add(8'hFF, 8'hFF, 1'b1);
      run_add(8'h00, 8'h00, 1'b0);
      run_add(8'h00, 8'h00, 1'b1);

      // start held high through RUN with new operands
      start = 1'b1; op_a = 8'h5A; op_b = 8'h33; cin = 1'b0;
      @(negedge clk);
      op_a = 8'h01; op_b = 8'h01;
      wait_done(n);
      check("hold_latency", n, 8);
      check("hold_sum1", sum, 8'h8D);
      @(negedge clk);
      check("hold_done_once", done, 0);
      check("hold_ready", ready, 1);
      @(negedge clk);
      start = 1'b0;
      check("hold_accept2", busy, 1);
      wait_done(n);
      check("hold_latency2", n, 8);
      check("hold_sum2", sum, 8'h02);
      @(negedge clk);

      // reset in the middle of an add
      start = 1'b1; op_a = 8'hAA; op_b = 8'h55; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_sum", sum, 0);
      check("mid_rst_cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         n += int'(done);
      end
      check("no_done_after_rst", n, 0);
      run_add(8'h10, 8'h20, 1'b0);

      // random adds against plain arithmetic
      repeat (300) run_add(8'($urandom), 8'($urandom), 1'($urandom));

      // WIDTH=1 unit, all operand combinations
      for (int k = 0; k < 8; k++) begin
         s1_start = 1'b1; s1_a = k[0]; s1_b = k[1]; s1_cin = k[2];
         e1 = {1'b0, k[0]} + {1'b0, k[1]} + {1'b0, k[2]};
         @(negedge clk);
         s1_start = 1'b0; s1_a = ~s1_a; s1_b = ~s1_b; s1_cin = ~s1_cin;
         check("w1_busy", s1_busy, 1);
         n = 0;
         while (!s1_done && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("w1_latency", n, 1);
         check("w1_sum", s1_sum, e1[0]);
         check("w1_cout", s1_cout, e1[1]);
         @(negedge clk);
         check("w1_ready", s1_ready, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
